muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at any even operand width. It sits beside the combinational ALU in the execute stage and handles operations the ALU cannot complete in one cycle. It uses a radix-2 shift-add/shift-subtract datapath, one bit per cycle, with valid/ready handshakes on input and output, a destination tag carried through, and a kill input for pipeline flushes.

Parameters:
DATAW, 32, operand/result width; must be even and >= 4
TAGW, 5, width of the opaque tag carried from request to result

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
kill  input  1  abort any operation in flight
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
op  input  3  operation, RV32M funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  DATAW  operand A (rs1, dividend)
b  input  DATAW  operand B (rs2, divisor)
tag_in  input  TAGW  tag, returned unchanged with the result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
result  output  DATAW  operation result
tag_out  output  TAGW  tag of the current result

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, out_valid 0, result 0, tag_out 0, iteration counter 0. in_ready is 1 once rst deasserts.
- States: IDLE, CALC, FIX, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept: an edge with in_valid & in_ready latches op, a, b and tag_in.
  - Normal operation: next state CALC, counter 0.
  - Operands are converted to magnitudes per op signedness. MULH and DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MUL, MULHU, DIVU and REMU treat both as unsigned.
  - The result sign is recorded at accept time.
- CALC: performs one step per cycle for exactly DATAW cycles, then moves to FIX.
  - Multiply step: 2*DATAW-bit accumulator, shift-add.
  - Divide step: restoring shift-subtract; quotient and remainder are each DATAW bits.
- FIX: one cycle. Applies two's-complement sign correction and selects the result, then moves to DONE.
  - MUL returns the low DATAW bits; MULH, MULHSU and MULHU return the high DATAW bits.
  - The quotient takes the sign of a^b. The remainder takes the sign of the dividend.
- Latency: out_valid rises DATAW+2 edges after the accepting edge (34 for DATAW=32).
- Special cases bypass CALC and FIX and go to DONE on the accepting edge, so out_valid is high the next cycle.
  - Divide by zero (b == 0): DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (DIV/REM with a = most-negative and b = all ones): DIV returns a; REM returns 0.
- DONE: result and tag_out are held stable while out_valid & !out_ready. The edge with out_valid & out_ready moves to IDLE. The next request is accepted no earlier than the following edge.
- kill: synchronous. When sampled high, state returns to IDLE on that edge from any state and no result is produced. kill has priority over accept and over the out handshake. A request presented with kill high is not accepted.
- rst asserted mid-operation: state is forced to IDLE immediately and all outputs return to their reset values; no partial result is ever presented.
- Operand, op and tag inputs are ignored outside the accepting edge.
- Shift and compare arithmetic sizes itself from DATAW; there are no hard-coded 32-bit constants.

Test Plan:
- DATAW=32, MUL a=7 b=6 tag=3 -> out_valid 34 edges after accept, result 42, tag_out 3; in_ready low throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF. MUL same operands -> 0x00000001.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100 b=7 -> 14. REMU same operands -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM same operands -> 0. Each has out_valid one cycle after accept.
- Hold out_ready low 10 cycles in DONE -> result and tag_out stable, in_ready 0. Raise out_ready -> IDLE next edge; back-to-back request accepted the edge after.
- kill at CALC cycle 5 -> IDLE next edge, no out_valid, a new request completes correctly. Assert rst mid-CALC -> out_valid 0 and result 0 immediately, in_ready 1 after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RV32M operation set.
// One result bit per cycle, valid/ready on both sides, tag carried through, kill flushes.
module muldiv_unit #(
    parameter int DATAW = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [DATAW-1:0] a,
    input  logic [DATAW-1:0] b,
    input  logic [TAGW-1:0]  tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] result,
    output logic [TAGW-1:0]  tag_out
);
    localparam int CNTW = $clog2(DATAW + 1);
    localparam logic [DATAW-1:0] MOST_NEG = {1'b1, {(DATAW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [DATAW-1:0]   a_mag_q, a_mag_d;
    logic [DATAW-1:0]   b_mag_q, b_mag_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*DATAW-1:0] acc_q, acc_d;
    logic [DATAW-1:0]   result_q, result_d;
    logic [TAGW-1:0]    tag_q, tag_d;

    logic               accept, is_div, is_rem, signed_a, signed_b;
    logic               a_neg, b_neg, div_zero, div_ovf, special;
    logic [DATAW-1:0]   special_res;
    logic [DATAW:0]     sum, trial, diff;
    logic [2*DATAW-1:0] prod;
    logic [DATAW-1:0]   quo, rem;

    // Request-side decode: signedness, magnitudes and the cases that skip the datapath.
    always_comb begin
        is_div   = op[2];
        is_rem   = op[2] & op[1];
        signed_a = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
        signed_b = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
        a_neg    = signed_a & a[DATAW-1];
        b_neg    = signed_b & b[DATAW-1];
        div_zero = is_div & (b == '0);
        div_ovf  = is_div & ~op[0] & (a == MOST_NEG) & (b == '1);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = is_rem ? a : '1;
        else          special_res = is_rem ? '0 : a;
        accept   = in_valid & in_ready & ~kill;
    end

    // FSM: state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state. The first CALC cycle loads the datapath; DATAW step cycles follow.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_d = special ? DONE : CALC;
                    cnt_d   = '0;
                end
                CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNTW'(DATAW)) state_d = FIX;
                end
                FIX:  state_d = DONE;
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = result_q;
        tag_out   = tag_q;
    end

    // Datapath: accumulator holds {hi, lo} for multiply and {remainder, quotient} for divide.
    always_comb begin
        op_d      = op_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        result_d  = result_q;
        tag_d     = tag_q;

        sum   = {1'b0, acc_q[2*DATAW-1:DATAW]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
        trial = acc_q[2*DATAW-1:DATAW-1];
        diff  = trial - {1'b0, b_mag_q};
        prod  = neg_q ? -acc_q : acc_q;
        quo   = neg_q ? -acc_q[DATAW-1:0] : acc_q[DATAW-1:0];
        rem   = neg_rem_q ? -acc_q[2*DATAW-1:DATAW] : acc_q[2*DATAW-1:DATAW];

        if (accept) begin
            op_d      = op;
            tag_d     = tag_in;
            a_mag_d   = a_neg ? -a : a;
            b_mag_d   = b_neg ? -b : b;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (special) result_d = special_res;
        end else if (state_q == CALC) begin
            if (cnt_q == '0)
                acc_d = {{DATAW{1'b0}}, a_mag_q};
            else if (!op_q[2])
                acc_d = {sum, acc_q[DATAW-1:1]};
            else if (!diff[DATAW])
                acc_d = {diff[DATAW-1:0], acc_q[DATAW-2:0], 1'b1};
            else
                acc_d = {trial[DATAW-1:0], acc_q[DATAW-2:0], 1'b0};
        end else if (state_q == FIX) begin
            case (op_q)
                3'd0:                   result_d = prod[DATAW-1:0];
                3'd1, 3'd2, 3'd3:       result_d = prod[2*DATAW-1:DATAW];
                3'd4, 3'd5:             result_d = quo;
                default:                result_d = rem;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
            tag_q     <= '0;
        end else begin
            op_q      <= op_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            tag_q     <= tag_d;
        end
    end

endmodule
